// File: rtl/alu_pkg.sv
// alu_pkg: shared RV32 decode constants, arbiter state encoding and the
// latched operand record used by alu_arbiter.
package alu_pkg;

  // Major opcodes
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // funct7 variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Everything latched from the winning requester at the accept edge.
  typedef struct packed {
    logic        id;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } alu_op_t;

  // Only the plain 32x32 low-half MUL takes the multi-cycle path.
  function automatic logic is_mul(input logic [6:0] opcode,
                                  input logic [6:0] funct7,
                                  input logic [2:0] funct3);
    return (opcode == OP_RTYPE) && (funct7 == F7_MUL) && (funct3 == F3_ADD_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant generator, purely combinational.
// Ports:
//   valid0_i, valid1_i : request valids
//   last_grant_i       : index granted most recently (state held by caller)
//   grant_o            : winning index (meaningful only when any_o is high)
//   any_o              : at least one request is valid
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic any_o
);

  assign any_o = valid0_i | valid1_i;

  // On a tie the requester that did not win last time goes first;
  // otherwise the lone valid requester wins.
  assign grant_o = (valid0_i && valid1_i) ? ~last_grant_i : valid1_i;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RV32 ALU between two requesters.
// Accepts one request at a time (round-robin), holds its fields on the ALU
// for 1 cycle (MUL_CYCLES for MUL), then returns the registered result with
// the requester index over a valid/ready response port.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   reqN_valid/ready                : request handshake, N = 0, 1
//   reqN_opcode/funct7/funct3/imm   : decoded fields
//   reqN_rs1_val/rs2_val            : operands
//   alu_*                           : operand register driven to the ALU
//   alu_rd_val                      : ALU result (combinational)
//   rsp_valid/ready, rsp_id, rsp_rd_val : response port
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_opcode,
  input  logic [6:0]  req0_funct7,
  input  logic [2:0]  req0_funct3,
  input  logic [11:0] req0_imm,
  input  logic [31:0] req0_rs1_val,
  input  logic [31:0] req0_rs2_val,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_opcode,
  input  logic [6:0]  req1_funct7,
  input  logic [2:0]  req1_funct3,
  input  logic [11:0] req1_imm,
  input  logic [31:0] req1_rs1_val,
  input  logic [31:0] req1_rs2_val,

  output logic [6:0]  alu_opcode,
  output logic [6:0]  alu_funct7,
  output logic [2:0]  alu_funct3,
  output logic [11:0] alu_imm,
  output logic [31:0] alu_rs1_val,
  output logic [31:0] alu_rs2_val,
  input  logic [31:0] alu_rd_val,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_rd_val
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  alu_op_t     op_q, op_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_rd_val_q, rsp_rd_val_d;

  logic        grant;
  logic        any;
  logic        idle_ok;
  alu_op_t     req_sel;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_o        (any)
  );

  // Ready is also masked by rst so nothing looks accepted while reset is held.
  assign idle_ok    = (state_q == IDLE) && !rst;
  assign req0_ready = idle_ok && any && !grant;
  assign req1_ready = idle_ok && any &&  grant;

  // NOTE: every signal gets a default before the case/if, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    req_sel = '0;
    if (grant) begin
      req_sel = '{id: 1'b1, opcode: req1_opcode, funct7: req1_funct7,
                  funct3: req1_funct3, imm: req1_imm,
                  rs1_val: req1_rs1_val, rs2_val: req1_rs2_val};
    end else begin
      req_sel = '{id: 1'b0, opcode: req0_opcode, funct7: req0_funct7,
                  funct3: req0_funct3, imm: req0_imm,
                  rs1_val: req0_rs1_val, rs2_val: req0_rs2_val};
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rsp_id_d     = rsp_id_q;
    rsp_rd_val_d = rsp_rd_val_q;

    case (state_q)
      IDLE: begin
        if (any) begin
          op_d         = req_sel;
          last_grant_d = grant;
          cnt_d        = is_mul(req_sel.opcode, req_sel.funct7, req_sel.funct3)
                         ? MUL_CNT : 4'd1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_rd_val_d = alu_rd_val;
          rsp_id_d     = op_q.id;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the operand register is reset too, so the ALU sees
  // zeros rather than X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // req0 wins the first tie
      cnt_q        <= '0;
      op_q         <= '0;
      rsp_id_q     <= 1'b0;
      rsp_rd_val_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_rd_val_q <= rsp_rd_val_d;
    end
  end

  assign alu_opcode  = op_q.opcode;
  assign alu_funct7  = op_q.funct7;
  assign alu_funct3  = op_q.funct3;
  assign alu_imm     = op_q.imm;
  assign alu_rs1_val = op_q.rs1_val;
  assign alu_rs2_val = op_q.rs2_val;

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_rd_val  = rsp_rd_val_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter, with a small
// behavioural ALU supplying alu_rd_val.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int MULC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [6:0]  req0_opcode, req0_funct7, req1_opcode, req1_funct7;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [11:0] req0_imm, req1_imm;
  logic [31:0] req0_rs1_val, req0_rs2_val, req1_rs1_val, req1_rs2_val;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [11:0] alu_imm;
  logic [31:0] alu_rs1_val, alu_rs2_val, alu_rd_val;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_rd_val;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MULC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opcode  (req0_opcode),
    .req0_funct7  (req0_funct7),
    .req0_funct3  (req0_funct3),
    .req0_imm     (req0_imm),
    .req0_rs1_val (req0_rs1_val),
    .req0_rs2_val (req0_rs2_val),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opcode  (req1_opcode),
    .req1_funct7  (req1_funct7),
    .req1_funct3  (req1_funct3),
    .req1_imm     (req1_imm),
    .req1_rs1_val (req1_rs1_val),
    .req1_rs2_val (req1_rs2_val),
    .alu_opcode   (alu_opcode),
    .alu_funct7   (alu_funct7),
    .alu_funct3   (alu_funct3),
    .alu_imm      (alu_imm),
    .alu_rs1_val  (alu_rs1_val),
    .alu_rs2_val  (alu_rs2_val),
    .alu_rd_val   (alu_rd_val),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_rd_val   (rsp_rd_val)
  );

  // Behavioural ALU: ADD/SUB/MUL, XOR for other R-type funct3, ADDI,
  // and a marker value for anything it does not implement.
  always_comb begin
    alu_rd_val = 32'hDEAD_BEEF;
    if (alu_opcode == OP_RTYPE) begin
      if (alu_funct3 == F3_ADD_SUB) begin
        if (alu_funct7 == F7_MUL)      alu_rd_val = alu_rs1_val * alu_rs2_val;
        else if (alu_funct7 == F7_ALT) alu_rd_val = alu_rs1_val - alu_rs2_val;
        else                           alu_rd_val = alu_rs1_val + alu_rs2_val;
      end else begin
        alu_rd_val = alu_rs1_val ^ alu_rs2_val;
      end
    end else if (alu_opcode == OP_ITYPE) begin
      alu_rd_val = alu_rs1_val + {{20{alu_imm[11]}}, alu_imm};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v, input logic [6:0] op,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      req0_valid = v; req0_opcode = op; req0_funct7 = f7; req0_funct3 = f3;
      req0_imm = 12'h000; req0_rs1_val = a; req0_rs2_val = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_funct7 = f7; req1_funct3 = f3;
      req1_imm = 12'h000; req1_rs1_val = a; req1_rs2_val = b;
    end
  endtask

  // Wait (bounded) for rsp_valid, sampling on falling edges.
  task automatic wait_rsp(input string tag);
    int w;
    w = 0;
    while (!rsp_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_wait"}, 32'(rsp_valid), 32'd1);
  endtask

  // Start from a falling edge in IDLE with rsp_ready high. Checks ready,
  // exact latency n, alu_* stability and the response contents.
  task automatic run_op(input string tag, input int who, input logic [6:0] op,
                        input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int n);
    set_req(who, 1'b1, op, f7, f3, a, b);
    #1;
    check({tag, "_ready"}, 32'(who == 0 ? req0_ready : req1_ready), 32'd1);
    @(posedge clk);
    #1;
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(rsp_valid), 32'd0);
      check({tag, "_alu_rs1"}, alu_rs1_val, a);
      check({tag, "_alu_rs2"}, alu_rs2_val, b);
      check({tag, "_alu_op"}, 32'(alu_opcode), 32'(op));
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(who));
    check({tag, "_rd"}, rsp_rd_val, exp);
    check({tag, "_alu_hold"}, alu_rs1_val, a);
    @(negedge clk);
    check({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_RTYPE, F7_BASE, F3_ADD_SUB, 32'd5, 32'd7);
    set_req(1, 1'b0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0);
    #2;
    // Reset state: valid held high, but nothing may be accepted.
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_rsp_id",     32'(rsp_id), 32'd0);
    check("rst_rsp_rd",     rsp_rd_val, 32'd0);
    check("rst_alu_op",     32'(alu_opcode), 32'd0);
    check("rst_alu_rs1",    alu_rs1_val, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add",  0, OP_RTYPE, F7_BASE, F3_ADD_SUB, 32'd5, 32'd7, 32'd12, 1);
    run_op("mul",  1, OP_RTYPE, F7_MUL,  F3_ADD_SUB, 32'd6, 32'd7, 32'd42, MULC);
    run_op("mulh", 1, OP_RTYPE, F7_MUL,  F3_SLL,     32'd3, 32'd5, 32'd6,  1);
    run_op("lui",  0, OP_LUI,   F7_BASE, 3'b000,     32'd0, 32'd0, 32'hDEAD_BEEF, 1);
    run_op("sub",  0, OP_RTYPE, F7_ALT,  F3_ADD_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);

    // Fairness after a fresh reset: both valid continuously -> 0,1,0,1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, OP_RTYPE, F7_BASE, F3_ADD_SUB, 32'd1,  32'd1);
    set_req(1, 1'b1, OP_RTYPE, F7_BASE, F3_ADD_SUB, 32'd10, 32'd10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_rsp("fair");
      check("fair_id", 32'(rsp_id), 32'(k % 2));
      check("fair_rd", rsp_rd_val, (k % 2 == 1) ? 32'd20 : 32'd2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure: rsp_ready low for 5 cycles while req1 waits.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_RTYPE, F7_ALT, F3_ADD_SUB, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    set_req(1, 1'b1, OP_RTYPE, F7_BASE, F3_ADD_SUB, 32'd2, 32'd2);
    @(negedge clk);
    wait_rsp("bp");
    repeat (5) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rd",    rsp_rd_val, 32'hFFFF_FFFE);
      check("bp_id",    32'(rsp_id), 32'd0);
      check("bp_r0",    32'(req0_ready), 32'd0);
      check("bp_r1",    32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_resume_r1",     32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    wait_rsp("bp2");
    check("bp2_id", 32'(rsp_id), 32'd1);
    check("bp2_rd", rsp_rd_val, 32'd4);
    @(negedge clk);

    // Reset in cycle 2 of a MUL: everything returns to reset values at once
    // and no response follows.
    set_req(0, 1'b1, OP_RTYPE, F7_MUL, F3_ADD_SUB, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_valid",  32'(rsp_valid), 32'd0);
    check("mrst_alu_op", 32'(alu_opcode), 32'd0);
    check("mrst_alu_f7", 32'(alu_funct7), 32'd0);
    check("mrst_alu_rs1", alu_rs1_val, 32'd0);
    check("mrst_rd",     rsp_rd_val, 32'd0);
    check("mrst_id",     32'(rsp_id), 32'd0);
    check("mrst_r0",     32'(req0_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
      check("mrst_alu_idle", alu_rs1_val, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
